// File: rtl/fetch_stage.sv
// MIPS instruction fetch stage with IF/ID pipeline register.
// One outstanding memory request at a time; a one-word skid buffer absorbs data that arrives during a stall.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic [5:0]  opcode
);

    typedef enum logic [1:0] {StReq, StWait, StSkid} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        drop_q, drop_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StReq;
            pc_q         <= RESET_PC;
            req_pc_q     <= RESET_PC;
            drop_q       <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc4_q   <= 32'h0;
            valid_q      <= 1'b0;
            instr_q      <= NOP_INSTR;
            pc4_q        <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            drop_q       <= drop_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        drop_d       = drop_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;

        unique case (state_q)
            StReq: begin
                if (imem_gnt) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = StReq;
                    end else if (!stall) begin
                        valid_d = 1'b1;
                        instr_d = imem_rdata;
                        pc4_d   = req_pc_q + 32'd4;
                        state_d = StReq;
                    end else begin
                        skid_instr_d = imem_rdata;
                        skid_pc4_d   = req_pc_q + 32'd4;
                        state_d      = StSkid;
                    end
                end
            end
            StSkid: begin
                if (!stall) begin
                    valid_d = 1'b1;
                    instr_d = skid_instr_q;
                    pc4_d   = skid_pc4_q;
                    state_d = StReq;
                end
            end
            default: state_d = StReq;
        endcase

        // Redirect overrides everything; a request already accepted must have its data dropped.
        if (redirect) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            pc_d    = redirect_pc;
            drop_d  = 1'b0;
            state_d = StReq;
            if ((state_q == StWait && !imem_rvalid) || (state_q == StReq && imem_gnt)) begin
                drop_d  = 1'b1;
                state_d = StWait;
            end
        end
    end

    assign imem_req    = (state_q == StReq) && !rst;
    assign imem_addr   = pc_q;
    assign if_id_valid = valid_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign opcode      = instr_q[31:26];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: linear stimulus, IF/ID loads checked against a scoreboard queue.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic [5:0]  opcode;

    int cmp_cnt = 0;
    int err_cnt = 0;
    logic [63:0] sb_q[$];
    logic [64:0] prev_key = '0;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_valid (if_id_valid),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4),
        .opcode      (opcode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp_cnt++;
        assert (got === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full REQ->WAIT->load transaction; push=1 means the word must reach IF/ID.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input bit push);
        chk("req_in_req", {31'b0, imem_req}, 32'd1);
        chk("addr", imem_addr, addr);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk("req_in_wait", {31'b0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        if (push) sb_q.push_back({data, addr + 32'd4});
        tick();
        imem_rvalid = 1'b0;
    endtask

    // Scoreboard monitor: every new IF/ID content must match the oldest expected word.
    always @(negedge clk) begin
        logic [64:0] key;
        logic [63:0] exp;
        key = {if_id_valid, if_id_instr, if_id_pc4};
        if (if_id_valid && key !== prev_key) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_load", if_id_instr, 32'hxxxx_xxxx);
            end else begin
                exp = sb_q.pop_front();
                chk("sb_instr", if_id_instr, exp[63:32]);
                chk("sb_pc4", if_id_pc4, exp[31:0]);
            end
        end
        prev_key = key;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        tick();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, if_id_valid}, 32'd0);
        chk("rst_instr", if_id_instr, 32'h0);
        chk("rst_pc4", if_id_pc4, 32'h0);
        chk("rst_opcode", {26'b0, opcode}, 32'h0);
        rst = 1'b0;
        tick();

        // Basic back-to-back fetches
        fetch(32'h0, 32'h8C01_0004, 1'b1);
        chk("opcode_lw", {26'b0, opcode}, 32'h23);
        fetch(32'h4, 32'h0000_0020, 1'b1);
        chk("opcode_r", {26'b0, opcode}, 32'h00);

        // Stall while the word at 8 returns: goes to skid, released after stall drops
        chk("addr8", imem_addr, 32'h8);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hAC02_0008;
        stall = 1'b1;
        sb_q.push_back({32'hAC02_0008, 32'hC});
        tick();
        imem_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("stall_req", {31'b0, imem_req}, 32'd0);
            chk("stall_hold_instr", if_id_instr, 32'h0000_0020);
            chk("stall_hold_pc4", if_id_pc4, 32'h8);
            tick();
        end
        chk("stall_hold_last", if_id_instr, 32'h0000_0020);
        stall = 1'b0;
        tick();
        chk("skid_release_instr", if_id_instr, 32'hAC02_0008);
        chk("skid_release_pc4", if_id_pc4, 32'hC);
        fetch(32'hC, 32'h0000_0001, 1'b1);

        // Redirect while waiting for addr 10; late data dropped
        chk("addr10", imem_addr, 32'h10);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        chk("redir_valid", {31'b0, if_id_valid}, 32'd0);
        chk("redir_instr", if_id_instr, 32'h0);
        chk("redir_wait_req", {31'b0, imem_req}, 32'd0);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        chk("drop_valid", {31'b0, if_id_valid}, 32'd0);
        fetch(32'h100, 32'h2001_0005, 1'b1);
        chk("opcode_addi", {26'b0, opcode}, 32'h08);

        // Redirect + stall with valid IF/ID and full skid
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h1111_2222;
        stall = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        chk("skid_full_req", {31'b0, imem_req}, 32'd0);
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        stall = 1'b0;
        chk("rs_valid", {31'b0, if_id_valid}, 32'd0);
        tick();
        chk("rs_skid_empty", {31'b0, if_id_valid}, 32'd0);

        // PC wrap at top of address space
        fetch(32'hFFFF_FFFC, 32'h0C00_0040, 1'b1);
        chk("wrap_pc4", if_id_pc4, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        // Redirect in REQ with simultaneous grant: request dropped, no +4
        imem_gnt = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        imem_gnt = 1'b0;
        redirect = 1'b0;
        chk("rg_req", {31'b0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata = 32'hBAD0_0001;
        tick();
        imem_rvalid = 1'b0;
        chk("rg_addr", imem_addr, 32'h200);
        chk("rg_valid", {31'b0, if_id_valid}, 32'd0);

        // Redirect coinciding with rvalid: data discarded, no drop pending
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hBAD0_0002;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0300;
        tick();
        imem_rvalid = 1'b0;
        redirect = 1'b0;
        fetch(32'h300, 32'h8C03_0300, 1'b1);

        // Async reset with a request outstanding; stale rvalid during reset ignored
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, if_id_valid}, 32'd0);
        chk("arst_instr", if_id_instr, 32'h0);
        chk("arst_pc4", if_id_pc4, 32'h0);
        chk("arst_opcode", {26'b0, opcode}, 32'h0);
        chk("arst_req", {31'b0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata = 32'hBAD0_0003;
        tick();
        imem_rvalid = 1'b0;
        rst = 1'b0;
        tick();
        fetch(32'h0, 32'h2402_0007, 1'b1);
        tick();
        tick();
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
